mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit of the RV32IM pipeline. It consumes the decoded memory controls carried down from decode (`mem_write`, `mem_store_type`, `wb_load`, `mem_load_type`) together with the EX-stage address and store data. It runs a request/grant/response transaction on the data-memory port and returns the sign- or zero-extended load result to writeback. While a transaction is in flight it stalls the pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: data-memory address width.

Ports:
- `clk` in 1: clock. The block uses one clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ex_valid` in 1: a valid instruction is present at the MEM-stage input.
- `mem_write` in 1: store instruction.
- `mem_store_type` in 2: store width. 00 = SB, 01 = SH, 10 = SW, 11 = no write.
- `wb_load` in 1: load instruction.
- `mem_load_type` in 3: load type. 000 = LB, 001 = LH, 010 = LW, 011 = LBU, 100 = LHU, 111 = full word.
- `addr` in ADDR_WIDTH: effective address from the ALU.
- `store_data` in 32: rs2 value.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: write enable.
- `dmem_addr` out ADDR_WIDTH: word-aligned address, with bits [1:0] = 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read data.
- `load_data` out 32: extended load result, registered.
- `load_valid` out 1: `load_data` is updated this cycle.
- `misalign` out 1: misaligned-access pulse.
- `stall` out 1: hold IF/ID/EX and the MEM inputs.

## Operation
- Access condition: `ex_valid & (wb_load | (mem_write & mem_store_type != 11))`. Store type 11 is a no-op. Load type 111 is treated as LW.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE → REQ when the access condition holds. On this transition the block latches the address, the type, `dmem_be`, `dmem_wdata` and `dmem_we`.
  - REQ: `dmem_req` = 1, and all `dmem_*` outputs are held stable until `dmem_gnt`. On `dmem_gnt`, a store goes to DONE and a load goes to RESP.
  - RESP: on `dmem_rvalid`, register the extracted data, then go to DONE.
  - DONE: lasts one cycle. `load_valid` = 1 for loads. Then go to IDLE, which does not re-launch the same instruction.
- `stall` is combinational. It is 1 in IDLE when the access condition holds, and 1 in REQ and RESP. It is 0 in DONE.
- Byte enables and write data:
  - SB: `be` = 0001 << `addr[1:0]`, `wdata` = {4{`store_data[7:0]`}}.
  - SH: `be` = 0011 << (2·`addr[1]`), `wdata` = {2{`store_data[15:0]`}}.
  - SW: `be` = 1111, `wdata` = `store_data`.
  - Loads drive `be` = 1111 and `we` = 0.
- Load extraction:
  - Byte lane is `rdata` >> 8·`addr[1:0]`. Half lane is `rdata` >> 16·`addr[1]`.
  - LB and LH sign-extend. LBU and LHU zero-extend. LW and 111 pass the word through.
- `dmem_rvalid` is ignored outside RESP. `dmem_gnt` is ignored outside REQ.

## Timing
- Reset values:
  - State: IDLE.
  - All zero: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `load_data`, `load_valid`, `misalign`.
  - `stall` follows its combinational rule.
- Reset asserted mid-transaction abandons the transaction and returns to IDLE. A late `rvalid` after reset is ignored.
- Minimum store latency: `stall` is high for 2 cycles, with the access seen in cycle 0 and grant in cycle 1. DONE occurs in cycle 2.
- Minimum load latency: `stall` is high for 3 cycles (grant in cycle 1, rvalid in cycle 2). `load_valid` and the new `load_data` appear in cycle 3.
- Each wait cycle on `gnt` or `rvalid` adds one stall cycle.
- `rvalid` comes no earlier than the cycle after `gnt`.
- `load_data` holds its value between loads.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are trapped. These are SH/LH/LHU with `addr[0]` = 1, and SW/LW/111 with `addr[1:0]` ≠ 0.
  - On a misaligned access, IDLE goes straight to DONE with no bus request. `stall` is 1 for 1 cycle.
  - `misalign` pulses for 1 cycle in DONE. `load_valid` = 0 and `load_data` is unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied to 0.
  - Half accesses ignore `addr[0]`, and word accesses ignore `addr[1:0]`. The access is forced to alignment.

## Test plan
- SB with `addr` = 0x103 and `store_data` = 0xA5, `gnt` immediate → `dmem_addr` = 0x100, `be` = 1000, `wdata` = 0xA5A5A5A5, `we` = 1, `stall` high 2 cycles.
- LB with `addr` = 0x202, `rdata` = 0x00800000 → `load_data` = 0xFFFFFF80. The same access as LBU → 0x00000080. `load_valid` is high in cycle 3.
- LHU with `addr` = 0x306, `gnt` delayed 3 cycles and `rvalid` delayed 2 → `dmem_*` stable through the wait, `stall` high 7 cycles, `load_data` = `rdata[31:16]` zero-extended.
- SW with `mem_store_type` = 11, and a cycle with `ex_valid` = 0 → no `dmem_req`, `stall` = 0.
- LW with `addr` = 0x402 and `MISALIGN_TRAP_EN` defined → no `dmem_req`, `misalign` pulse for 1 cycle, `load_valid` = 0. With the macro undefined → `dmem_addr` = 0x400, normal load.
- `rst_n` dropped while in RESP, then a stray `rvalid` → all outputs zero, FSM in IDLE, `load_valid` stays 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: request/grant/response data-memory port,
// byte-lane steering for stores, and sign/zero extension for loads.
// Ports: clk, rst_n; decoded controls ex_valid, mem_write, mem_store_type,
//   wb_load, mem_load_type; ALU addr and store_data; dmem_* bus signals;
//   load_data/load_valid to writeback; misalign pulse; stall to pipeline.
// Optional build macro MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  mem_write,
   input  logic [1:0]            mem_store_type,
   input  logic                  wb_load,
   input  logic [2:0]            mem_load_type,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           store_data,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [31:0]           dmem_rdata,
   output logic [31:0]           load_data,
   output logic                  load_valid,
   output logic                  misalign,
   output logic                  stall
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state, state_nx;
   logic        access, is_st;
   logic        mis_c;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [1:0]  a_lsb;
   logic [2:0]  ld_type;
   logic        is_ld, mis_q;
   logic [7:0]  byte_l;
   logic [15:0] half_l;
   logic [31:0] ext;

   // Load wins if decode ever flags both; store type 11 is a no-op.
   assign is_st  = mem_write & (mem_store_type != 2'b11);
   assign access = ex_valid & (wb_load | is_st);

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = store_data;
      if (!wb_load) begin
         case (mem_store_type)
            2'b00: begin
               be_c    = 4'b0001 << addr[1:0];
               wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
               be_c    = 4'b0011 << {addr[1], 1'b0};
               wdata_c = {2{store_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      mis_c = 1'b0;
      if (wb_load) begin
         case (mem_load_type)
            3'b001, 3'b100: mis_c = addr[0];
            3'b010, 3'b111: mis_c = |addr[1:0];
            default:        mis_c = 1'b0;
         endcase
      end else begin
         case (mem_store_type)
            2'b01:   mis_c = addr[0];
            2'b10:   mis_c = |addr[1:0];
            default: mis_c = 1'b0;
         endcase
      end
   end
`else
   // Without trapping, lane selection simply ignores the low bits.
   assign mis_c = 1'b0;
`endif

   assign byte_l = dmem_rdata[{a_lsb, 3'b000} +: 8];
   assign half_l = dmem_rdata[{a_lsb[1], 4'b0000} +: 16];

   always_comb begin
      case (ld_type)
         3'b000:  ext = {{24{byte_l[7]}}, byte_l};
         3'b001:  ext = {{16{half_l[15]}}, half_l};
         3'b011:  ext = {24'd0, byte_l};
         3'b100:  ext = {16'd0, half_l};
         default: ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= 4'b0000;
         dmem_wdata <= 32'd0;
         load_data  <= 32'd0;
         a_lsb      <= 2'b00;
         ld_type    <= 3'b000;
         is_ld      <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && access) begin
            a_lsb   <= addr[1:0];
            ld_type <= mem_load_type;
            is_ld   <= wb_load;
            mis_q   <= mis_c;
            if (!mis_c) begin
               dmem_we    <= ~wb_load;
               dmem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
               dmem_be    <= be_c;
               dmem_wdata <= wdata_c;
            end
         end
         if (state == RESP && dmem_rvalid)
            load_data <= ext;
      end
   end

   always_comb begin
      state_nx   = state;
      dmem_req   = 1'b0;
      stall      = 1'b0;
      load_valid = 1'b0;
      misalign   = 1'b0;
      case (state)
         IDLE: begin
            stall = access;
            if (access)
               state_nx = mis_c ? DONE : REQ;
         end
         REQ: begin
            dmem_req = 1'b1;
            stall    = 1'b1;
            if (dmem_gnt)
               state_nx = is_ld ? RESP : DONE;
         end
         RESP: begin
            stall = 1'b1;
            if (dmem_rvalid)
               state_nx = DONE;
         end
         DONE: begin
            load_valid = is_ld & ~mis_q;
            misalign   = mis_q;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Inputs change 1ns after posedge; outputs are sampled 4ns after posedge.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, mem_write, wb_load;
   logic [1:0]  mem_store_type;
   logic [2:0]  mem_load_type;
   logic [31:0] addr, store_data;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] load_data;
   logic        load_valid, misalign, stall;

   int total = 0;
   int bad   = 0;

   int          st_cnt, rq_cnt, mis_cnt, lv_at;
   bit          unstable;
   logic [31:0] s_addr, s_wd;
   logic [3:0]  s_be;
   logic        s_we;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .mem_write(mem_write),
      .mem_store_type(mem_store_type), .wb_load(wb_load),
      .mem_load_type(mem_load_type), .addr(addr),
      .store_data(store_data), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .load_data(load_data),
      .load_valid(load_valid), .misalign(misalign),
      .stall(stall)
   );

   task automatic set_in(input bit v, input bit w,
                         input logic [1:0] st, input bit ld,
                         input logic [2:0] lt,
                         input logic [31:0] a, input logic [31:0] sd);
      ex_valid = v; mem_write = w; mem_store_type = st;
      wb_load = ld; mem_load_type = lt; addr = a; store_data = sd;
   endtask

   // Drives one instruction (already on the inputs) through to its
   // DONE / no-stall cycle and records what the bus and stall did.
   task automatic run_txn(input int g_at, input int r_at,
                          input logic [31:0] rd);
      bit first = 1;
      bit done = 0;
      st_cnt = 0; rq_cnt = 0; mis_cnt = 0; lv_at = -1; unstable = 0;
      dmem_rdata = rd;
      for (int c = 0; c < 40; c++) begin
         dmem_gnt = (c == g_at);
         dmem_rvalid = (c == r_at);
         #3;
         if (load_valid) lv_at = c;
         if (misalign) mis_cnt++;
         if (dmem_req) begin
            rq_cnt++;
            if (first) begin
               s_addr = dmem_addr; s_be = dmem_be;
               s_wd = dmem_wdata; s_we = dmem_we; first = 0;
            end else if (dmem_addr !== s_addr || dmem_be !== s_be ||
                         dmem_wdata !== s_wd || dmem_we !== s_we)
               unstable = 1;
         end
         if (!stall) begin
            done = 1;
            ex_valid = 0; dmem_gnt = 0; dmem_rvalid = 0;
            @(posedge clk); #1;
            break;
         end
         st_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL txn_timeout got stall stuck exp release");
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      set_in(0, 0, 2'b11, 0, 3'b000, 32'h0, 32'h0);
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
      repeat (2) @(posedge clk);
      #4;
      total++;
      if ({dmem_req, dmem_we, dmem_be, misalign, load_valid} !== 8'd0) begin
         bad++;
         $display("FAIL rst_ctl got %b exp 0",
                  {dmem_req, dmem_we, dmem_be, misalign, load_valid});
      end
      total++;
      if (dmem_addr !== 0 || dmem_wdata !== 0 || load_data !== 0) begin
         bad++;
         $display("FAIL rst_data got %h %h %h exp 0",
                  dmem_addr, dmem_wdata, load_data);
      end
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL rst_stall got %b exp 0", stall);
      end
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_sb();
      set_in(1, 1, 2'b00, 0, 3'b000, 32'h103, 32'h000000A5);
      run_txn(1, -1, 32'h0);
      total++;
      if (st_cnt !== 2) begin
         bad++; $display("FAIL sb_stall got %0d exp 2", st_cnt);
      end
      total++;
      if (s_addr !== 32'h100 || s_be !== 4'b1000 || s_we !== 1'b1) begin
         bad++;
         $display("FAIL sb_bus got %h %b %b exp 100 1000 1",
                  s_addr, s_be, s_we);
      end
      total++;
      if (s_wd !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL sb_wdata got %h exp a5a5a5a5", s_wd);
      end
      total++;
      if (rq_cnt !== 1 || lv_at !== -1) begin
         bad++;
         $display("FAIL sb_req got %0d lv %0d exp 1 -1", rq_cnt, lv_at);
      end
   endtask

   task automatic test_sh();
      set_in(1, 1, 2'b01, 0, 3'b000, 32'h102, 32'hFFFF1234);
      run_txn(1, -1, 32'h0);
      total++;
      if (s_be !== 4'b1100 || s_wd !== 32'h12341234 ||
          s_addr !== 32'h100) begin
         bad++;
         $display("FAIL sh_bus got %b %h %h exp 1100 12341234 100",
                  s_be, s_wd, s_addr);
      end
   endtask

   task automatic test_lb_lbu();
      set_in(1, 0, 2'b11, 1, 3'b000, 32'h202, 32'h0);
      run_txn(1, 2, 32'h00800000);
      total++;
      if (load_data !== 32'hFFFFFF80 || lv_at !== 3 || st_cnt !== 3) begin
         bad++;
         $display("FAIL lb got %h lv %0d st %0d exp ffffff80 3 3",
                  load_data, lv_at, st_cnt);
      end
      total++;
      if (s_be !== 4'b1111 || s_we !== 1'b0 || s_addr !== 32'h200) begin
         bad++;
         $display("FAIL lb_bus got %b %b %h exp 1111 0 200",
                  s_be, s_we, s_addr);
      end
      set_in(1, 0, 2'b11, 1, 3'b011, 32'h202, 32'h0);
      run_txn(1, 2, 32'h00800000);
      total++;
      if (load_data !== 32'h00000080 || lv_at !== 3) begin
         bad++;
         $display("FAIL lbu got %h lv %0d exp 00000080 3",
                  load_data, lv_at);
      end
   endtask

   task automatic test_lhu_wait();
      set_in(1, 0, 2'b11, 1, 3'b100, 32'h306, 32'h0);
      run_txn(4, 6, 32'hBEEF1234);
      total++;
      if (st_cnt !== 7 || lv_at !== 7) begin
         bad++;
         $display("FAIL lhu_wait got st %0d lv %0d exp 7 7",
                  st_cnt, lv_at);
      end
      total++;
      if (unstable || rq_cnt !== 4 || s_addr !== 32'h304) begin
         bad++;
         $display("FAIL lhu_hold got unst %0d req %0d %h exp 0 4 304",
                  unstable, rq_cnt, s_addr);
      end
      total++;
      if (load_data !== 32'h0000BEEF) begin
         bad++; $display("FAIL lhu_data got %h exp 0000beef", load_data);
      end
   endtask

   task automatic test_noop();
      set_in(1, 1, 2'b11, 0, 3'b000, 32'h40, 32'h1);
      run_txn(0, 0, 32'h0);
      total++;
      if (st_cnt !== 0 || rq_cnt !== 0) begin
         bad++;
         $display("FAIL noop_st11 got st %0d req %0d exp 0 0",
                  st_cnt, rq_cnt);
      end
      set_in(0, 0, 2'b11, 1, 3'b010, 32'h40, 32'h1);
      run_txn(0, 0, 32'h0);
      total++;
      if (st_cnt !== 0 || rq_cnt !== 0 || lv_at !== -1) begin
         bad++;
         $display("FAIL noop_inval got st %0d req %0d lv %0d exp 0 0 -1",
                  st_cnt, rq_cnt, lv_at);
      end
      total++;
      if (load_data !== 32'h0000BEEF) begin
         bad++; $display("FAIL noop_hold got %h exp 0000beef", load_data);
      end
   endtask

   task automatic test_misalign();
      set_in(1, 0, 2'b11, 1, 3'b010, 32'h402, 32'h0);
      run_txn(1, 2, 32'h13572468);
`ifdef MISALIGN_TRAP_EN
      total++;
      if (st_cnt !== 1 || rq_cnt !== 0 || mis_cnt !== 1 || lv_at !== -1) begin
         bad++;
         $display("FAIL mis_trap got st %0d req %0d mis %0d lv %0d exp 1 0 1 -1",
                  st_cnt, rq_cnt, mis_cnt, lv_at);
      end
      total++;
      if (load_data !== 32'h0000BEEF) begin
         bad++; $display("FAIL mis_hold got %h exp 0000beef", load_data);
      end
`else
      total++;
      if (s_addr !== 32'h400 || st_cnt !== 3 || mis_cnt !== 0) begin
         bad++;
         $display("FAIL mis_align got %h st %0d mis %0d exp 400 3 0",
                  s_addr, st_cnt, mis_cnt);
      end
      total++;
      if (load_data !== 32'h13572468 || lv_at !== 3) begin
         bad++;
         $display("FAIL mis_data got %h lv %0d exp 13572468 3",
                  load_data, lv_at);
      end
`endif
   endtask

   task automatic test_back_to_back();
      set_in(1, 1, 2'b10, 0, 3'b000, 32'h10, 32'hDEADBEEF);
      run_txn(1, -1, 32'h0);
      total++;
      if (s_wd !== 32'hDEADBEEF || s_be !== 4'b1111 || st_cnt !== 2) begin
         bad++;
         $display("FAIL b2b_sw got %h %b st %0d exp deadbeef 1111 2",
                  s_wd, s_be, st_cnt);
      end
      set_in(1, 0, 2'b11, 1, 3'b001, 32'h22, 32'h0);
      run_txn(1, 2, 32'h8001CAFE);
      total++;
      if (load_data !== 32'hFFFF8001 || lv_at !== 3) begin
         bad++;
         $display("FAIL b2b_lh got %h lv %0d exp ffff8001 3",
                  load_data, lv_at);
      end
   endtask

   task automatic test_reset_mid();
      set_in(1, 0, 2'b11, 1, 3'b010, 32'h500, 32'h0);
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      dmem_gnt = 1;
      @(posedge clk); #1;
      dmem_gnt = 0;
      #3;
      total++;
      if (stall !== 1'b1 || dmem_req !== 1'b0) begin
         bad++;
         $display("FAIL rm_resp got stall %b req %b exp 1 0",
                  stall, dmem_req);
      end
      rst_n = 0;
      ex_valid = 0;
      #1;
      total++;
      if ({dmem_req, dmem_we, dmem_be, load_valid, misalign, stall} !== 9'd0 ||
          dmem_addr !== 0 || dmem_wdata !== 0 || load_data !== 0) begin
         bad++;
         $display("FAIL rm_zero got %b %h %h %h exp 0",
                  {dmem_req, dmem_we, dmem_be, load_valid, misalign, stall},
                  dmem_addr, dmem_wdata, load_data);
      end
      @(posedge clk); #1;
      rst_n = 1;
      dmem_rvalid = 1;
      #3;
      total++;
      if (load_valid !== 1'b0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL rm_stray got lv %b stall %b exp 0 0",
                  load_valid, stall);
      end
      @(posedge clk); #1;
      dmem_rvalid = 0;
      #3;
      total++;
      if (load_data !== 0 || load_valid !== 1'b0 || dmem_req !== 1'b0) begin
         bad++;
         $display("FAIL rm_after got %h lv %b req %b exp 0 0 0",
                  load_data, load_valid, dmem_req);
      end
   endtask

   initial begin
      test_reset();
      test_sb();
      test_sh();
      test_lb_lbu();
      test_lhu_wait();
      test_noop();
      test_misalign();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
